// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: shared definitions for the load/store unit.
//   - RV32I load/store funct3 encodings
//   - completion error codes
//   - LSU control state encoding
//   - default timeout budget
package riscv_lsu_pkg;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Completion error codes
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    // Cycles allowed in REQ+WAIT before the op is abandoned
    localparam int unsigned TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StWait = 2'b10,
        StResp = 2'b11
    } lsu_state_e;

endpackage

// File: rtl/riscv_lsu_align.sv
// lsu_align: combinational lane steering for the load/store unit.
//   we         in   1 = store, 0 = load
//   funct3     in   RV32I load/store funct3
//   off        in   byte offset (addr[1:0])
//   wdata      in   raw store data (rs2)
//   rdata      in   raw memory read word
//   be         out  byte enables (1111 for loads)
//   wdata_rep  out  store data replicated across all lanes
//   rdata_ext  out  load data shifted down and sign/zero extended
//   misaligned out  access not naturally aligned for its size
//   illegal    out  funct3 is not a valid load/store encoding
module lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misaligned,
    output logic        illegal
);

    logic [31:0] shifted;

    // Stores only use 000..010; loads additionally allow the unsigned 100/101.
    always_comb begin
        if (we) begin
            illegal = funct3[2] | (funct3[1:0] == 2'b11);
        end else begin
            illegal = (funct3 == 3'b011) | (funct3[2:1] == 2'b11);
        end
    end

    // funct3[1:0] is the access size for every legal encoding.
    always_comb begin
        misaligned = 1'b0;
        if (!illegal) begin
            unique case (funct3[1:0])
                2'b01:   misaligned = off[0];
                2'b10:   misaligned = (off != 2'b00);
                default: misaligned = 1'b0;
            endcase
        end
    end

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        if (we) begin
            unique case (funct3[1:0])
                2'b00: begin
                    be        = 4'b0001 << off;
                    wdata_rep = {4{wdata[7:0]}};
                end
                2'b01: begin
                    be        = 4'b0011 << off;
                    wdata_rep = {2{wdata[15:0]}};
                end
                default: begin
                    be        = 4'b1111;
                    wdata_rep = wdata;
                end
            endcase
        end
    end

    assign shifted = rdata >> {off, 3'b000};

    always_comb begin
        rdata_ext = shifted;
        unique case (funct3)
            F3_LB:   rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  rdata_ext = {24'h000000, shifted[7:0]};
            F3_LHU:  rdata_ext = {16'h0000, shifted[15:0]};
            default: rdata_ext = shifted;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between the execute stage and a handshaked data memory.
//   clk, reset            clock; asynchronous active-high reset
//   req_valid/req_ready   op handshake from execute (ready only while idle)
//   req_we/funct3/addr    op type, size and effective byte address
//   req_wdata, req_rd     store data; load destination register
//   mem_req/we/addr/...   memory request, held stable until mem_gnt
//   mem_gnt               memory accepted the request
//   mem_rvalid/mem_rdata  load data return
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata/rd          extended load data and destination (0 for stores)
//   rsp_err/err_code      error flag and cause
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [4:0]        rsp_rd,
    output logic              rsp_err,
    output logic [1:0]        rsp_err_code
);

    lsu_state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        funct3_q;
    logic              we_q;
    logic [4:0]        rd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       rdata_q;
    logic [1:0]        err_code_q;

    // Shared alignment unit: while idle it checks the incoming op, afterwards
    // it steers the captured op so the memory-side outputs stay stable.
    logic        al_we;
    logic [2:0]  al_funct3;
    logic [1:0]  al_off;
    logic [3:0]  al_be;
    logic [31:0] al_wdata_rep;
    logic [31:0] al_rdata_ext;
    logic        al_misaligned;
    logic        al_illegal;

    logic       idle;
    logic       accept;
    logic       in_flight;
    logic       timeout_hit;
    logic       complete;
    logic       load_done;
    logic       timeout_err;
    logic [1:0] accept_err;

    assign idle      = (state_q == StIdle);
    assign al_we     = idle ? req_we : we_q;
    assign al_funct3 = idle ? req_funct3 : funct3_q;
    assign al_off    = idle ? req_addr[1:0] : addr_q[1:0];

    lsu_align u_align (
        .we         (al_we),
        .funct3     (al_funct3),
        .off        (al_off),
        .wdata      (wdata_q),
        .rdata      (mem_rdata),
        .be         (al_be),
        .wdata_rep  (al_wdata_rep),
        .rdata_ext  (al_rdata_ext),
        .misaligned (al_misaligned),
        .illegal    (al_illegal)
    );

    assign accept    = idle && req_valid;
    assign in_flight = (state_q == StReq) || (state_q == StWait);

    // Counter is cleared at accept, so it reads k-1 in the k-th REQ/WAIT cycle;
    // this gives exactly TIMEOUT cycles of REQ+WAIT before giving up.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // A load may get data in the grant cycle; rvalid is meaningless before gnt.
    assign load_done = !we_q && mem_rvalid &&
                       (((state_q == StReq) && mem_gnt) || (state_q == StWait));
    assign complete  = ((state_q == StReq) && mem_gnt && we_q) || load_done;
    assign timeout_err = in_flight && !complete && timeout_hit;

    always_comb begin
        if (al_illegal) begin
            accept_err = ERR_ILLEGAL;
        end else if (al_misaligned) begin
            accept_err = ERR_MISALIGN;
        end else begin
            accept_err = ERR_NONE;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = (accept_err != ERR_NONE) ? StResp : StReq;
                end
            end
            StReq: begin
                if (complete || timeout_err) begin
                    state_d = StResp;
                end else if (mem_gnt) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (complete || timeout_err) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Captured request, timeout counter and response payload
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            funct3_q   <= '0;
            we_q       <= 1'b0;
            rd_q       <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            if (accept) begin
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                funct3_q   <= req_funct3;
                we_q       <= req_we;
                rd_q       <= req_rd;
                cnt_q      <= '0;
                rdata_q    <= '0;
                err_code_q <= accept_err;
            end
            if (in_flight) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (load_done) begin
                rdata_q <= al_rdata_ext;
            end
            if (timeout_err) begin
                err_code_q <= ERR_TIMEOUT;
            end
        end
    end

    // Outputs are gated by state so everything idles at zero
    always_comb begin
        req_ready    = idle;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_be       = 4'b0000;
        rsp_valid    = 1'b0;
        rsp_rdata    = '0;
        rsp_rd       = '0;
        rsp_err      = 1'b0;
        rsp_err_code = ERR_NONE;
        if (state_q == StReq) begin
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
            mem_wdata = al_wdata_rep;
            mem_be    = al_be;
        end
        if (state_q == StResp) begin
            rsp_valid    = 1'b1;
            rsp_rdata    = rdata_q;
            rsp_rd       = we_q ? 5'd0 : rd_q;
            rsp_err      = (err_code_q != ERR_NONE);
            rsp_err_code = err_code_q;
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: randomized and directed self-checking bench for riscv_lsu.
// The model predicts each transaction from the memory timing the bench itself
// chooses (grant delay g, data delay r); one negedge process compares outputs.
module tb_riscv_lsu;

    localparam int ADDR_W = 32;
    localparam int TO     = 16;
    localparam int CNT_W  = 5;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic        rsp_err;
    logic [1:0]  rsp_err_code;

    riscv_lsu #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TO),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_rd       (rsp_rd),
        .rsp_err      (rsp_err),
        .rsp_err_code (rsp_err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [1:0] model_err(input logic we, input logic [2:0] f3,
                                             input logic [31:0] addr);
        int sz;
        if (we && f3 > 3'd2) return 2'd3;
        if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 2'd3;
        sz = size_of(f3);
        if ((int'(addr[1:0]) % sz) != 0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [3:0] model_be(input logic we, input logic [2:0] f3,
                                            input logic [31:0] addr);
        int sz;
        if (!we) return 4'hF;
        sz = size_of(f3);
        return 4'(((1 << sz) - 1) << addr[1:0]);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] w;
        int sz;
        sz = size_of(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rd_word);
        logic [31:0] sh, mask, v;
        int sz;
        sz   = size_of(f3);
        sh   = rd_word >> (8 * off);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v    = sh & mask;
        if (!f3[2] && sz < 4 && sh[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- per-cycle expectations and compare ----------------
    logic        chk_en = 1'b0;
    logic        exp_ready, exp_mem_req, exp_mem_we, exp_rsp_valid;
    logic [31:0] exp_mem_addr, exp_mem_wdata, exp_rsp_rdata;
    logic [3:0]  exp_mem_be;
    logic [4:0]  exp_rsp_rd;
    logic [1:0]  exp_err_code;
    int          cyc = 1000;

    logic [31:0] cap_mem_addr, cap_mem_wdata, cap_rsp_rdata;
    logic [3:0]  cap_mem_be;
    logic [4:0]  cap_rsp_rd;
    logic [1:0]  cap_err_code;
    int          cap_rsp_cycle = -1;
    int          n_req_cyc = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("mem_req", 32'(mem_req), 32'(exp_mem_req));
            if (exp_mem_req) begin
                check("mem_we", 32'(mem_we), 32'(exp_mem_we));
                check("mem_addr", mem_addr, exp_mem_addr);
                check("mem_be", 32'(mem_be), 32'(exp_mem_be));
                if (exp_mem_we) check("mem_wdata", mem_wdata, exp_mem_wdata);
            end
            check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
            if (exp_rsp_valid) begin
                check("rsp_rdata", rsp_rdata, exp_rsp_rdata);
                check("rsp_rd", 32'(rsp_rd), 32'(exp_rsp_rd));
                check("rsp_err", 32'(rsp_err), 32'(exp_err_code != 2'd0));
                check("rsp_err_code", 32'(rsp_err_code), 32'(exp_err_code));
            end
        end
        if (cyc == 0) n_req_cyc <= mem_req ? 1 : 0;
        else if (mem_req) n_req_cyc <= n_req_cyc + 1;
        if (mem_req) begin
            cap_mem_addr  <= mem_addr;
            cap_mem_wdata <= mem_wdata;
            cap_mem_be    <= mem_be;
        end
        if (rsp_valid) begin
            cap_rsp_rdata <= rsp_rdata;
            cap_rsp_rd    <= rsp_rd;
            cap_err_code  <= rsp_err_code;
            cap_rsp_cycle <= cyc;
        end
    end

    // ---------------- drivers ----------------
    // Runs one op from accept (cycle 0) through its response. Memory grants g
    // cycles after mem_req first rises; load data follows r cycles after grant.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd,
                           input int g, input int r, input logic [31:0] rword);
        logic [1:0] e;
        int rsp_k, req_end;
        logic acc_ok;
        e = model_err(we, f3, addr);
        acc_ok = (e == 2'd0);
        if (!acc_ok) begin
            rsp_k = 1; req_end = 0;
        end else if (we) begin
            if (g < TO) begin rsp_k = g + 2; req_end = g + 1; end
            else begin rsp_k = TO + 1; req_end = TO; e = 2'd2; end
        end else begin
            if (g + r < TO) begin rsp_k = g + r + 2; req_end = g + 1; end
            else begin rsp_k = TO + 1; req_end = (g < TO) ? g + 1 : TO; e = 2'd2; end
        end
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
        for (int k = 0; k <= rsp_k; k++) begin
            cyc        = k;
            req_valid  = (k == 0);
            mem_gnt    = acc_ok && (g < TO) && (k == g + 1);
            mem_rvalid = acc_ok && !we && (g < TO) && (k == g + 1 + r);
            mem_rdata  = mem_rvalid ? rword : $urandom();
            exp_ready     = (k == 0);
            exp_mem_req   = (k >= 1) && (k <= req_end);
            exp_mem_we    = we;
            exp_mem_addr  = {addr[31:2], 2'b00};
            exp_mem_be    = model_be(we, f3, addr);
            exp_mem_wdata = model_wdata(f3, wdata);
            exp_rsp_valid = (k == rsp_k);
            exp_rsp_rdata = (e == 2'd0 && !we) ? model_load(f3, addr[1:0], rword) : 32'd0;
            exp_rsp_rd    = we ? 5'd0 : rd;
            exp_err_code  = e;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input logic stray);
        for (int k = 0; k < n; k++) begin
            cyc = 100 + k;
            req_valid = 1'b0; mem_gnt = 1'b0;
            mem_rvalid = stray; mem_rdata = $urandom();
            exp_ready = 1'b1; exp_mem_req = 1'b0; exp_rsp_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        mem_rvalid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        int          g, r, sz;

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0;
        req_wdata = '0; req_rd = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        exp_ready = 1'b1; exp_mem_req = 1'b0; exp_rsp_valid = 1'b0;
        exp_mem_we = 1'b0; exp_mem_addr = '0; exp_mem_wdata = '0; exp_mem_be = '0;
        exp_rsp_rdata = '0; exp_rsp_rd = '0; exp_err_code = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset mem_be", 32'(mem_be), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        // Directed: SW with immediate grant
        run_txn(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd3, 0, 0, 32'd0);
        check("sw mem_addr", cap_mem_addr, 32'h100);
        check("sw mem_be", 32'(cap_mem_be), 32'hF);
        check("sw rsp cycle", 32'(cap_rsp_cycle), 32'd2);
        check("sw err", 32'(cap_err_code), 32'd0);
        // SB on top byte lane
        run_txn(1'b1, 3'b000, 32'h103, 32'h0000_00A5, 5'd0, 0, 0, 32'd0);
        check("sb mem_be", 32'(cap_mem_be), 32'h8);
        check("sb mem_wdata", cap_mem_wdata, 32'hA5A5_A5A5);
        check("sb mem_addr", cap_mem_addr, 32'h100);
        // LB / LBU with data 3 cycles after grant
        run_txn(1'b0, 3'b000, 32'h202, 32'd0, 5'd7, 0, 3, 32'h12F0_3456);
        check("lb rdata", cap_rsp_rdata, 32'hFFFF_FFF0);
        check("lb rd", 32'(cap_rsp_rd), 32'd7);
        run_txn(1'b0, 3'b100, 32'h202, 32'd0, 5'd7, 0, 3, 32'h12F0_3456);
        check("lbu rdata", cap_rsp_rdata, 32'h0000_00F0);
        // Zero-wait load latency
        run_txn(1'b0, 3'b010, 32'h40, 32'd0, 5'd1, 0, 1, 32'h8765_4321);
        check("lw rsp cycle", 32'(cap_rsp_cycle), 32'd3);
        check("lw rdata", cap_rsp_rdata, 32'h8765_4321);
        // Misaligned and illegal
        run_txn(1'b0, 3'b001, 32'h301, 32'd0, 5'd4, 0, 1, 32'd0);
        check("lh misalign cycle", 32'(cap_rsp_cycle), 32'd1);
        check("lh misalign code", 32'(cap_err_code), 32'd1);
        check("lh misalign no mem_req", 32'(n_req_cyc), 32'd0);
        run_txn(1'b0, 3'b011, 32'h300, 32'd0, 5'd4, 0, 1, 32'd0);
        check("illegal code", 32'(cap_err_code), 32'd3);
        // Timeout with grant withheld, then stray rvalid while idle
        run_txn(1'b0, 3'b010, 32'h500, 32'd0, 5'd9, TO + 4, 0, 32'd0);
        check("timeout code", 32'(cap_err_code), 32'd2);
        check("timeout req cycles", 32'(n_req_cyc), 32'(TO));
        check("timeout rsp cycle", 32'(cap_rsp_cycle), 32'(TO + 1));
        idle_cycles(3, 1'b1);
        // Timeout boundaries: last allowed grant / data cycle, and one past it
        run_txn(1'b1, 3'b010, 32'h600, 32'h1234_5678, 5'd0, TO - 1, 0, 32'd0);
        run_txn(1'b0, 3'b001, 32'h602, 32'd0, 5'd2, 0, TO - 1, 32'h8001_7FFF);
        run_txn(1'b0, 3'b001, 32'h602, 32'd0, 5'd2, 0, TO, 32'h8001_7FFF);
        run_txn(1'b0, 3'b101, 32'h602, 32'd0, 5'd2, 2, 0, 32'h8001_7FFF);

        // Reset while waiting for load data
        chk_en = 1'b0;
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400; req_rd = 5'd9;
        req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1 mem_gnt = 1'b0;
        check("wait before reset ready", 32'(req_ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("abort req_ready", 32'(req_ready), 32'd1);
        check("abort mem_req", 32'(mem_req), 32'd0);
        check("abort rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        idle_cycles(2, 1'b1);
        run_txn(1'b1, 3'b010, 32'h100, 32'hCAFE_F00D, 5'd0, 0, 0, 32'd0);
        check("post-reset sw cycle", 32'(cap_rsp_cycle), 32'd2);
        check("post-reset sw err", 32'(cap_err_code), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 250; i++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                f3 = 3'($urandom_range(0, 7));
            end else if (we) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end
            addr = $urandom();
            sz = 1 << f3[1:0];
            if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(sz) - 32'd1);
            g = ($urandom_range(0, 15) == 0) ? TO - 2 + $urandom_range(0, 4) :
                                                $urandom_range(0, 3);
            r = ($urandom_range(0, 15) == 0) ? TO - 3 + $urandom_range(0, 4) :
                                                $urandom_range(0, 4);
            run_txn(we, f3, addr, $urandom(), 5'($urandom_range(0, 31)), g, r, $urandom());
            if ($urandom_range(0, 7) == 0) idle_cycles($urandom_range(1, 2), 1'($urandom_range(0, 1)));
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
